// File: rtl/lab_univ_shift_reg.sv
// lab_univ_shift_reg
//   Universal WIDTH-bit shift register with parallel load, logical and
//   arithmetic shifts, rotates and clear. A start/busy/done sequencer repeats
//   one shift/rotate operation a programmable number of times, one position
//   per clock.
//
// Ports
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   en      - enable for single-cycle operations (IDLE only)
//   mode    - 000 hold, 001 load, 010 shl, 011 shr, 100 rotl, 101 rotr,
//             110 asr, 111 clear
//   d       - parallel load data
//   ser_in  - serial fill bit (LSB on shl, MSB on shr), sampled live
//   start   - begin a multi-cycle run of mode (shift/rotate modes only)
//   amt     - number of single-position steps in a run
//   q       - register contents
//   so_msb  - q[WIDTH-1]
//   so_lsb  - q[0]
//   busy    - run in progress (registered)
//   done    - one-cycle pulse when a run completes (registered)
module lab_univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CW        = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    input  logic             start,
    input  logic [CW-1:0]    amt,
    output logic [WIDTH-1:0] q,
    output logic             so_msb,
    output logic             so_lsb,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_HOLD  = 3'b000,
        OP_LOAD  = 3'b001,
        OP_SHL   = 3'b010,
        OP_SHR   = 3'b011,
        OP_ROTL  = 3'b100,
        OP_ROTR  = 3'b101,
        OP_ASR   = 3'b110,
        OP_CLEAR = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    op_t           op;
    op_t           mode_op;
    logic [CW-1:0] cnt;

    assign mode_op = op_t'(mode);
    assign so_msb  = q[WIDTH-1];
    assign so_lsb  = q[0];

    // Next value of the register for one application of operation o.
    function automatic logic [WIDTH-1:0] apply_op(
        input op_t              o,
        input logic [WIDTH-1:0] v,
        input logic             si,
        input logic [WIDTH-1:0] ld
    );
        case (o)
            OP_LOAD:  return ld;
            OP_SHL:   return {v[WIDTH-2:0], si};
            OP_SHR:   return {si, v[WIDTH-1:1]};
            OP_ROTL:  return {v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROTR:  return {v[0], v[WIDTH-1:1]};
            OP_ASR:   return {v[WIDTH-1], v[WIDTH-1:1]};
            OP_CLEAR: return '0;
            default:  return v;
        endcase
    endfunction

    function automatic logic is_run_op(input op_t o);
        return o inside {OP_SHL, OP_SHR, OP_ROTL, OP_ROTR, OP_ASR};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= RESET_VAL;
            cnt   <= '0;
            op    <= OP_HOLD;
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    // start wins over en, but only for shift/rotate modes;
                    // otherwise the cycle falls through to the en path.
                    if (start && is_run_op(mode_op)) begin
                        op    <= mode_op;
                        cnt   <= amt;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else if (en) begin
                        q <= apply_op(mode_op, q, ser_in, d);
                    end
                end
                S_RUN: begin
                    if (cnt != '0) begin
                        q   <= apply_op(op, q, ser_in, d);
                        cnt <= cnt - CW'(1);
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lab_univ_shift_reg.sv
// Directed testbench for lab_univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5).
module tb_lab_univ_shift_reg;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       ser_in;
    logic       start;
    logic [3:0] amt;
    logic [7:0] q;
    logic       so_msb;
    logic       so_lsb;
    logic       busy;
    logic       done;

    int n_cmp;
    int n_err;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROTL  = 3'b100;
    localparam logic [2:0] M_ROTR  = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    lab_univ_shift_reg #(
        .WIDTH    (8),
        .RESET_VAL(8'hA5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .ser_in(ser_in),
        .start (start),
        .amt   (amt),
        .q     (q),
        .so_msb(so_msb),
        .so_lsb(so_lsb),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        en = 1'b1; mode = M_LOAD; d = v; start = 1'b0;
        tick();
        en = 1'b0;
    endtask

    task automatic test_reset();
        do_load(8'h3C);
        // mid-cycle asynchronous reset
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (q !== 8'hA5 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: q=%h busy=%b done=%b, want q=a5 busy=0 done=0", q, busy, done);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (q !== 8'hA5) begin
            n_err++;
            $display("FAIL reset_hold: q=%h, want a5", q);
        end
    endtask

    task automatic test_load();
        do_load(8'h3C);
        n_cmp++;
        if (q !== 8'h3C) begin
            n_err++;
            $display("FAIL load: q=%h, want 3c", q);
        end
    endtask

    task automatic test_single_modes();
        logic [2:0] m [6];
        logic [7:0] e [6];
        m = '{M_SHL, M_SHR, M_ROTL, M_ROTR, M_ASR, M_CLEAR};
        e = '{8'h2D, 8'hCB, 8'h2D, 8'h4B, 8'hCB, 8'h00};
        for (int i = 0; i < 6; i++) begin
            do_load(8'h96);
            en = 1'b1; mode = m[i]; ser_in = 1'b1;
            tick();
            en = 1'b0;
            n_cmp++;
            if (q !== e[i] || so_msb !== e[i][7] || so_lsb !== e[i][0]) begin
                n_err++;
                $display("FAIL single_mode_%0d: q=%h msb=%b lsb=%b, want %h", i, q, so_msb, so_lsb, e[i]);
            end
        end
        do_load(8'h96);
        en = 1'b0; mode = M_SHL;
        tick();
        n_cmp++;
        if (q !== 8'h96) begin
            n_err++;
            $display("FAIL en0_hold: q=%h, want 96", q);
        end
    endtask

    task automatic test_multi_rotate();
        logic [7:0] e [3];
        e = '{8'h03, 8'h06, 8'h0C};
        do_load(8'h81);
        mode = M_ROTL; amt = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0 || q !== 8'h81) begin
            n_err++;
            $display("FAIL rot_accept: q=%h busy=%b done=%b, want 81 1 0", q, busy, done);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (q !== e[k] || busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL rot_step_%0d: q=%h busy=%b done=%b, want %h 1 0", k + 1, q, busy, done, e[k]);
            end
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h0C) begin
            n_err++;
            $display("FAIL rot_done: q=%h busy=%b done=%b, want 0c 0 1", q, busy, done);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rot_idle: busy=%b done=%b, want 0 0", busy, done);
        end
        // full-width rotate returns to the start value
        do_load(8'h81);
        mode = M_ROTL; amt = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        n_cmp++;
        if (q !== 8'h81 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rot8_value: q=%h busy=%b, want 81 1", q, busy);
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || q !== 8'h81) begin
            n_err++;
            $display("FAIL rot8_done: q=%h done=%b, want 81 1", q, done);
        end
        tick();
    endtask

    task automatic test_boundaries();
        // amt = 0
        do_load(8'h5A);
        mode = M_SHL; amt = 4'd0; start = 1'b1; ser_in = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL amt0_busy: busy=%b done=%b, want 1 0", busy, done);
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h5A) begin
            n_err++;
            $display("FAIL amt0_done: q=%h busy=%b done=%b, want 5a 0 1", q, busy, done);
        end
        tick();
        // asr saturates to sign
        do_load(8'h80);
        mode = M_ASR; amt = 4'd15; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) tick();
        n_cmp++;
        if (done !== 1'b1 || q !== 8'hFF) begin
            n_err++;
            $display("FAIL asr15: q=%h done=%b, want ff 1", q, done);
        end
        tick();
        // shr saturates to ser_in fill
        do_load(8'hFF);
        mode = M_SHR; amt = 4'd9; start = 1'b1; ser_in = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        n_cmp++;
        if (done !== 1'b1 || q !== 8'h00) begin
            n_err++;
            $display("FAIL shr9: q=%h done=%b, want 00 1", q, done);
        end
        tick();
        // start with a non-run mode is ignored, en path applies
        en = 1'b1; mode = M_LOAD; d = 8'hE7; start = 1'b1; amt = 4'd3;
        tick();
        en = 1'b0; start = 1'b0;
        n_cmp++;
        if (q !== 8'hE7 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_load: q=%h busy=%b, want e7 0", q, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic       si [5];
        logic [7:0] e  [5];
        logic [2:0] junk [5];
        si   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        e    = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16};
        junk = '{M_CLEAR, M_LOAD, M_ROTR, M_ASR, M_CLEAR};
        do_load(8'h00);
        mode = M_SHL; amt = 4'd5; start = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            en = ~en; mode = junk[k]; d = 8'hFF - 8'(k); start = 1'b1;
            amt = 4'(k); ser_in = si[k];
            tick();
            n_cmp++;
            if (q !== e[k] || busy !== 1'b1) begin
                n_err++;
                $display("FAIL intf_step_%0d: q=%h busy=%b, want %h 1", k + 1, q, busy, e[k]);
            end
        end
        mode = M_SHL; start = 1'b1;
        tick();
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h16) begin
            n_err++;
            $display("FAIL intf_done: q=%h busy=%b done=%b, want 16 0 1", q, busy, done);
        end
        // start during DONE is ignored
        mode = M_ROTL; amt = 4'd2; start = 1'b1; en = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 8'h16) begin
            n_err++;
            $display("FAIL intf_ignore: q=%h busy=%b done=%b, want 16 0 0", q, busy, done);
        end
        tick();
        start = 1'b0; en = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || q !== 8'h16) begin
            n_err++;
            $display("FAIL b2b_accept: q=%h busy=%b, want 16 1", q, busy);
        end
        tick();
        tick();
        n_cmp++;
        if (q !== 8'h58) begin
            n_err++;
            $display("FAIL b2b_value: q=%h, want 58", q);
        end
        tick();
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_done: done=%b, want 1", done);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        do_load(8'h00);
        mode = M_SHL; amt = 4'd6; start = 1'b1; ser_in = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (q !== 8'h03 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre: q=%h busy=%b, want 03 1", q, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (q !== 8'hA5 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: q=%h busy=%b done=%b, want a5 0 0", q, busy, done);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || q !== 8'hA5) begin
                n_err++;
                $display("FAIL mid_nodone_%0d: q=%h busy=%b done=%b, want a5 0 0", k, q, busy, done);
            end
        end
        mode = M_ROTR; amt = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if (q !== 8'hD2 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_rerun: q=%h busy=%b, want d2 1", q, busy);
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rerun_done: busy=%b done=%b, want 0 1", busy, done);
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0; en = 1'b0; mode = M_HOLD; d = '0;
        ser_in = 1'b0; start = 1'b0; amt = '0;
        tick();
        n_cmp++;
        if (q !== 8'hA5 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL por_state: q=%h busy=%b done=%b, want a5 0 0", q, busy, done);
        end
        rst_n = 1'b1;
        tick();
        test_reset();
        test_load();
        test_single_modes();
        test_multi_rotate();
        test_boundaries();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
